evr_drp_arbiter: RTL and testbench

- Shares the single MGT DRP port of the EVR transceiver between two requesters: A (host register bridge) and B (on-chip auto-configuration / eye-scan sequencer).
- Latches one-cycle requests, grants round-robin, and drives exactly one DRP transaction at a time.
- Returns read data and completion to the owning requester only.
- Guards against a missing drp_drdy with a timeout and sticky error reporting.
- Sits in the drp_clk domain between the requesters and the MGT wrapper DRP pins.

---
 rtl/evr_drp_arbiter.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_evr_drp_arbiter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/evr_drp_arbiter.sv
// evr_drp_arbiter: shares the single MGT DRP port between requester A (host
// register bridge) and requester B (auto-configuration / eye-scan sequencer).
//
// Requester handshake: x_den is a one-cycle strobe that is accepted only while
// x_busy is low, and {x_dwe, x_daddr, x_di} are sampled with it. Every accepted
// request is answered by exactly one x_drdy pulse carrying x_do; x_timeout
// pulses with x_drdy when the MGT never answered. x_busy rises the cycle after
// the strobe and falls the cycle after x_drdy. A strobe seen while x_busy is
// high is dropped silently.
module evr_drp_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [15:0] TIMEOUT_DATA   = 16'hFFFF
) (
  input  logic        drp_clk,
  input  logic        reset_n,
  // requester A
  input  logic        a_den,
  input  logic        a_dwe,
  input  logic [8:0]  a_daddr,
  input  logic [15:0] a_di,
  output logic [15:0] a_do,
  output logic        a_drdy,
  output logic        a_timeout,
  output logic        a_busy,
  // requester B
  input  logic        b_den,
  input  logic        b_dwe,
  input  logic [8:0]  b_daddr,
  input  logic [15:0] b_di,
  output logic [15:0] b_do,
  output logic        b_drdy,
  output logic        b_timeout,
  output logic        b_busy,
  // MGT DRP pins
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [8:0]  drp_daddr,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  // error reporting
  output logic [7:0]  timeout_count,
  output logic        timeout_sticky
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic       OWN_A        = 1'b0;
  localparam logic       OWN_B        = 1'b1;
  localparam logic [7:0] TIMEOUT_LOAD = 8'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;

  // request slots
  logic        pend_a_q, pend_a_d;
  logic        pend_b_q, pend_b_d;
  logic        slot_a_dwe_q, slot_a_dwe_d;
  logic [8:0]  slot_a_daddr_q, slot_a_daddr_d;
  logic [15:0] slot_a_di_q, slot_a_di_d;
  logic        slot_b_dwe_q, slot_b_dwe_d;
  logic [8:0]  slot_b_daddr_q, slot_b_daddr_d;
  logic [15:0] slot_b_di_q, slot_b_di_d;

  // arbitration and timeout
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic [7:0]  cnt_q, cnt_d;

  // registered outputs
  logic        drp_den_q, drp_den_d;
  logic        drp_dwe_q, drp_dwe_d;
  logic [8:0]  drp_daddr_q, drp_daddr_d;
  logic [15:0] drp_di_q, drp_di_d;
  logic [15:0] a_do_q, a_do_d;
  logic        a_drdy_q, a_drdy_d;
  logic        a_timeout_q, a_timeout_d;
  logic [15:0] b_do_q, b_do_d;
  logic        b_drdy_q, b_drdy_d;
  logic        b_timeout_q, b_timeout_d;
  logic [7:0]  timeout_count_q, timeout_count_d;
  logic        timeout_sticky_q, timeout_sticky_d;

  // transaction finish decoded in WAIT
  logic        fin;
  logic        fin_abort;
  logic [15:0] fin_data;

  // Next-state, arbitration, request capture and output decode.
  always_comb begin
    state_d          = state_q;
    pend_a_d         = pend_a_q;
    pend_b_d         = pend_b_q;
    slot_a_dwe_d     = slot_a_dwe_q;
    slot_a_daddr_d   = slot_a_daddr_q;
    slot_a_di_d      = slot_a_di_q;
    slot_b_dwe_d     = slot_b_dwe_q;
    slot_b_daddr_d   = slot_b_daddr_q;
    slot_b_di_d      = slot_b_di_q;
    owner_d          = owner_q;
    last_grant_d     = last_grant_q;
    cnt_d            = cnt_q;
    drp_den_d        = 1'b0;
    drp_dwe_d        = 1'b0;
    drp_daddr_d      = drp_daddr_q;
    drp_di_d         = drp_di_q;
    a_do_d           = 16'h0000;
    a_drdy_d         = 1'b0;
    a_timeout_d      = 1'b0;
    b_do_d           = 16'h0000;
    b_drdy_d         = 1'b0;
    b_timeout_d      = 1'b0;
    timeout_count_d  = timeout_count_q;
    timeout_sticky_d = timeout_sticky_q;
    fin              = 1'b0;
    fin_abort        = 1'b0;
    fin_data         = 16'h0000;

    case (state_q)
      S_IDLE: begin
        if (pend_a_q || pend_b_q) begin
          // last_grant only moves on a genuine tie, so a lone requester
          // does not disturb the round-robin order for the next tie.
          if (pend_a_q && pend_b_q) begin
            owner_d      = ~last_grant_q;
            last_grant_d = ~last_grant_q;
          end else begin
            owner_d = pend_b_q ? OWN_B : OWN_A;
          end
          state_d   = S_ISSUE;
          drp_den_d = 1'b1;
          if (owner_d == OWN_B) begin
            drp_dwe_d   = slot_b_dwe_q;
            drp_daddr_d = slot_b_daddr_q;
            drp_di_d    = slot_b_di_q;
          end else begin
            drp_dwe_d   = slot_a_dwe_q;
            drp_daddr_d = slot_a_daddr_q;
            drp_di_d    = slot_a_di_q;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = TIMEOUT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // drdy is tested first so it wins over a coincident expiry
        if (drp_drdy) begin
          fin      = 1'b1;
          fin_data = drp_do;
        end else if (cnt_q == 8'd0) begin
          fin       = 1'b1;
          fin_abort = 1'b1;
          fin_data  = TIMEOUT_DATA;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DONE: begin
        if (owner_q == OWN_B) begin
          pend_b_d = 1'b0;
        end else begin
          pend_a_d = 1'b0;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (fin) begin
      state_d = S_DONE;
      if (owner_q == OWN_B) begin
        b_drdy_d    = 1'b1;
        b_do_d      = fin_data;
        b_timeout_d = fin_abort;
      end else begin
        a_drdy_d    = 1'b1;
        a_do_d      = fin_data;
        a_timeout_d = fin_abort;
      end
      if (fin_abort) begin
        timeout_sticky_d = 1'b1;
        if (timeout_count_q != 8'hFF) begin
          timeout_count_d = timeout_count_q + 8'd1;
        end
      end
    end

    // pending stays high through DONE, so a strobe can never collide with
    // the owner's clear above
    if (a_den && !pend_a_q) begin
      pend_a_d       = 1'b1;
      slot_a_dwe_d   = a_dwe;
      slot_a_daddr_d = a_daddr;
      slot_a_di_d    = a_di;
    end
    if (b_den && !pend_b_q) begin
      pend_b_d       = 1'b1;
      slot_b_dwe_d   = b_dwe;
      slot_b_daddr_d = b_daddr;
      slot_b_di_d    = b_di;
    end
  end

  // FSM state register.
  always_ff @(posedge drp_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Slots, arbitration state, timeout counter and all registered outputs.
  always_ff @(posedge drp_clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_a_q         <= 1'b0;
      pend_b_q         <= 1'b0;
      slot_a_dwe_q     <= 1'b0;
      slot_a_daddr_q   <= 9'h000;
      slot_a_di_q      <= 16'h0000;
      slot_b_dwe_q     <= 1'b0;
      slot_b_daddr_q   <= 9'h000;
      slot_b_di_q      <= 16'h0000;
      owner_q          <= OWN_A;
      last_grant_q     <= OWN_B;
      cnt_q            <= 8'd0;
      drp_den_q        <= 1'b0;
      drp_dwe_q        <= 1'b0;
      drp_daddr_q      <= 9'h000;
      drp_di_q         <= 16'h0000;
      a_do_q           <= 16'h0000;
      a_drdy_q         <= 1'b0;
      a_timeout_q      <= 1'b0;
      b_do_q           <= 16'h0000;
      b_drdy_q         <= 1'b0;
      b_timeout_q      <= 1'b0;
      timeout_count_q  <= 8'd0;
      timeout_sticky_q <= 1'b0;
    end else begin
      pend_a_q         <= pend_a_d;
      pend_b_q         <= pend_b_d;
      slot_a_dwe_q     <= slot_a_dwe_d;
      slot_a_daddr_q   <= slot_a_daddr_d;
      slot_a_di_q      <= slot_a_di_d;
      slot_b_dwe_q     <= slot_b_dwe_d;
      slot_b_daddr_q   <= slot_b_daddr_d;
      slot_b_di_q      <= slot_b_di_d;
      owner_q          <= owner_d;
      last_grant_q     <= last_grant_d;
      cnt_q            <= cnt_d;
      drp_den_q        <= drp_den_d;
      drp_dwe_q        <= drp_dwe_d;
      drp_daddr_q      <= drp_daddr_d;
      drp_di_q         <= drp_di_d;
      a_do_q           <= a_do_d;
      a_drdy_q         <= a_drdy_d;
      a_timeout_q      <= a_timeout_d;
      b_do_q           <= b_do_d;
      b_drdy_q         <= b_drdy_d;
      b_timeout_q      <= b_timeout_d;
      timeout_count_q  <= timeout_count_d;
      timeout_sticky_q <= timeout_sticky_d;
    end
  end

  assign drp_den        = drp_den_q;
  assign drp_dwe        = drp_dwe_q;
  assign drp_daddr      = drp_daddr_q;
  assign drp_di         = drp_di_q;
  assign a_do           = a_do_q;
  assign a_drdy         = a_drdy_q;
  assign a_timeout      = a_timeout_q;
  assign a_busy         = pend_a_q;
  assign b_do           = b_do_q;
  assign b_drdy         = b_drdy_q;
  assign b_timeout      = b_timeout_q;
  assign b_busy         = pend_b_q;
  assign timeout_count  = timeout_count_q;
  assign timeout_sticky = timeout_sticky_q;

endmodule

// File: tb/tb_evr_drp_arbiter.sv
// tb_evr_drp_arbiter: directed scenarios plus randomized traffic for
// evr_drp_arbiter, checked every cycle against a transaction-age model.
module tb_evr_drp_arbiter;

  localparam int          T  = 8;
  localparam logic [15:0] TD = 16'hFFFF;

  // ---------------- clock / reset / DUT ----------------
  logic        drp_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        a_den = 1'b0, a_dwe = 1'b0;
  logic [8:0]  a_daddr = '0;
  logic [15:0] a_di = '0;
  logic        b_den = 1'b0, b_dwe = 1'b0;
  logic [8:0]  b_daddr = '0;
  logic [15:0] b_di = '0;
  logic [15:0] drp_do = '0;
  logic        drp_drdy = 1'b0;
  logic [15:0] a_do, b_do, drp_di;
  logic        a_drdy, a_timeout, a_busy, b_drdy, b_timeout, b_busy;
  logic        drp_den, drp_dwe, timeout_sticky;
  logic [8:0]  drp_daddr;
  logic [7:0]  timeout_count;

  always #5 drp_clk = ~drp_clk;

  evr_drp_arbiter #(.TIMEOUT_CYCLES(T), .TIMEOUT_DATA(TD)) dut (
    .drp_clk(drp_clk), .reset_n(reset_n),
    .a_den(a_den), .a_dwe(a_dwe), .a_daddr(a_daddr), .a_di(a_di),
    .a_do(a_do), .a_drdy(a_drdy), .a_timeout(a_timeout), .a_busy(a_busy),
    .b_den(b_den), .b_dwe(b_dwe), .b_daddr(b_daddr), .b_di(b_di),
    .b_do(b_do), .b_drdy(b_drdy), .b_timeout(b_timeout), .b_busy(b_busy),
    .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_daddr(drp_daddr), .drp_di(drp_di),
    .drp_do(drp_do), .drp_drdy(drp_drdy),
    .timeout_count(timeout_count), .timeout_sticky(timeout_sticky)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge drp_clk);
    cyc++;
  end

  // ---------------- MGT responder ----------------
  // resp_delay = cycles from drp_den to drdy; 0 means never answer.
  int          resp_delay = 1;
  int          resp_cd = 0;
  logic [15:0] resp_data = 16'h0000;
  bit          resp_rand = 1'b0;
  bit          stray_req = 1'b0;

  initial forever begin
    @(negedge drp_clk);
    drp_drdy = 1'b0;
    drp_do   = 16'($urandom);
    if (!reset_n) begin
      resp_cd = 0;
    end else begin
      if (resp_cd > 0) begin
        resp_cd--;
        if (resp_cd == 0) begin
          drp_drdy = 1'b1;
          if (!resp_rand) drp_do = resp_data;
        end
      end
      if (drp_den) resp_cd = resp_delay;
      if (stray_req) begin
        drp_drdy  = 1'b1;
        stray_req = 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  // Tracks the in-flight transaction by its age in cycles since drp_den:
  // age 0 is the strobe cycle, ages 1..T+1 may accept drdy, and a
  // transaction still unanswered at age T+1 is aborted. The cycle after a
  // completion is the only one that delivers to the requester.
  logic [1:0]  m_pend = '0;
  logic        s_dwe[2];
  logic [8:0]  s_addr[2];
  logic [15:0] s_di[2];
  logic        m_last = 1'b1;
  logic        m_own = 1'b0;
  int          m_age = -1;
  bit          m_cmp = 1'b0;
  logic [1:0]  op;
  logic        e_den = 0, e_dwe = 0;
  logic [8:0]  e_daddr = '0;
  logic [15:0] e_di = '0;
  logic        e_drdy[2], e_to[2];
  logic [15:0] e_do[2];
  int          e_cnt = 0;
  logic        e_sticky = 0;

  initial forever begin
    @(posedge drp_clk or negedge reset_n);
    e_den = 0; e_dwe = 0;
    e_drdy[0] = 0; e_drdy[1] = 0; e_to[0] = 0; e_to[1] = 0;
    e_do[0] = '0; e_do[1] = '0;
    if (!reset_n) begin
      m_pend = '0; m_last = 1'b1; m_own = 1'b0; m_age = -1; m_cmp = 0;
      e_daddr = '0; e_di = '0; e_cnt = 0; e_sticky = 0;
    end else begin
      op = m_pend;
      if (m_cmp) begin
        m_pend[m_own] = 1'b0;
        m_cmp = 0;
      end else if (m_age >= 1) begin
        if (drp_drdy) begin
          m_age = -1; m_cmp = 1;
          e_drdy[m_own] = 1; e_do[m_own] = drp_do;
        end else if (m_age == T + 1) begin
          m_age = -1; m_cmp = 1;
          e_drdy[m_own] = 1; e_to[m_own] = 1; e_do[m_own] = TD;
          e_sticky = 1;
          if (e_cnt < 255) e_cnt++;
        end else begin
          m_age++;
        end
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (op != 2'b00) begin
        if (op == 2'b11) begin
          m_own  = ~m_last;
          m_last = m_own;
        end else begin
          m_own = op[1];
        end
        m_age = 0;
        e_den = 1; e_dwe = s_dwe[m_own]; e_daddr = s_addr[m_own]; e_di = s_di[m_own];
      end
      if (a_den && !op[0]) begin
        m_pend[0] = 1'b1; s_dwe[0] = a_dwe; s_addr[0] = a_daddr; s_di[0] = a_di;
      end
      if (b_den && !op[1]) begin
        m_pend[1] = 1'b1; s_dwe[1] = b_dwe; s_addr[1] = b_daddr; s_di[1] = b_di;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge drp_clk);
    if (chk_en) begin
      check("drp_den",   32'(drp_den),   32'(e_den));
      check("drp_dwe",   32'(drp_dwe),   32'(e_dwe));
      check("drp_daddr", 32'(drp_daddr), 32'(e_daddr));
      check("drp_di",    32'(drp_di),    32'(e_di));
      check("a_drdy",    32'(a_drdy),    32'(e_drdy[0]));
      check("a_timeout", 32'(a_timeout), 32'(e_to[0]));
      check("a_do",      32'(a_do),      32'(e_do[0]));
      check("a_busy",    32'(a_busy),    32'(m_pend[0]));
      check("b_drdy",    32'(b_drdy),    32'(e_drdy[1]));
      check("b_timeout", 32'(b_timeout), 32'(e_to[1]));
      check("b_do",      32'(b_do),      32'(e_do[1]));
      check("b_busy",    32'(b_busy),    32'(m_pend[1]));
      check("timeout_count",  32'(timeout_count),  32'(e_cnt));
      check("timeout_sticky", 32'(timeout_sticky), 32'(e_sticky));
    end
  end

  // ---------------- event monitor for literal checks ----------------
  int          den_cnt = 0, a_cnt = 0, b_cnt = 0;
  int          last_den_cyc = 0, last_a_cyc = 0, last_b_cyc = 0;
  logic [8:0]  last_den_addr = '0;
  logic        last_den_dwe = 0, last_a_to = 0, last_b_to = 0;
  logic [15:0] last_den_di = '0, last_a_do = '0, last_b_do = '0;
  logic [8:0]  den_log[$];

  initial forever begin
    @(negedge drp_clk);
    if (drp_den) begin
      den_cnt++; last_den_cyc = cyc; last_den_addr = drp_daddr;
      last_den_dwe = drp_dwe; last_den_di = drp_di;
      den_log.push_back(drp_daddr);
    end
    if (a_drdy) begin
      a_cnt++; last_a_cyc = cyc; last_a_do = a_do; last_a_to = a_timeout;
    end
    if (b_drdy) begin
      b_cnt++; last_b_cyc = cyc; last_b_do = b_do; last_b_to = b_timeout;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge drp_clk);
    #1;
  endtask

  task automatic req_a(input logic dwe, input logic [8:0] addr, input logic [15:0] di);
    a_den = 1'b1; a_dwe = dwe; a_daddr = addr; a_di = di;
    tick(1);
    a_den = 1'b0;
  endtask

  task automatic req_b(input logic dwe, input logic [8:0] addr, input logic [15:0] di);
    b_den = 1'b1; b_dwe = dwe; b_daddr = addr; b_di = di;
    tick(1);
    b_den = 1'b0;
  endtask

  task automatic wait_den(input string name);
    int start;
    bit ok;
    start = den_cnt;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick(1);
      if (den_cnt > start) ok = 1'b1;
    end
    check(name, 32'(ok), 32'd1);
  endtask

  // waits for the requester's completion, then one more cycle so busy is low
  task automatic wait_rsp(input bit is_b, input string name);
    int start;
    bit ok;
    start = is_b ? b_cnt : a_cnt;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick(1);
      if ((is_b ? b_cnt : a_cnt) > start) ok = 1'b1;
    end
    check(name, 32'(ok), 32'd1);
    tick(1);
  endtask

  // ---------------- stimulus ----------------
  int t, d1, a0, b0, n0;

  initial begin
    tick(3);
    chk_en = 1'b1;
    check("reset_drp",   32'({drp_den, drp_dwe, drp_daddr, drp_di}), 32'd0);
    check("reset_a",     32'({a_do, a_drdy, a_timeout, a_busy}), 32'd0);
    check("reset_b",     32'({b_do, b_drdy, b_timeout, b_busy}), 32'd0);
    check("reset_err",   32'({timeout_count, timeout_sticky}), 32'd0);
    @(negedge drp_clk);
    #2 reset_n = 1'b1;
    tick(2);

    // single read
    resp_delay = 3; resp_data = 16'h1234; resp_rand = 0;
    b0 = b_cnt; t = cyc;
    req_a(1'b0, 9'h05F, 16'h0000);
    wait_den("rd_den_seen");
    check("rd_den_lat", 32'(last_den_cyc - t), 32'd2);
    check("rd_daddr", 32'(last_den_addr), 32'h05F);
    check("rd_dwe", 32'(last_den_dwe), 32'd0);
    wait_rsp(1'b0, "rd_drdy_seen");
    check("rd_drdy_lat", 32'(last_a_cyc - last_den_cyc), 32'd4);
    check("rd_a_do", 32'(last_a_do), 32'h1234);
    check("rd_b_quiet", 32'(b_cnt - b0), 32'd0);

    // simultaneous requests, twice
    resp_delay = 1; t = cyc;
    a_den = 1; a_dwe = 1; a_daddr = 9'h011; a_di = 16'hA5A5;
    b_den = 1; b_dwe = 0; b_daddr = 9'h1B0; b_di = 16'h0000;
    tick(1);
    a_den = 0; b_den = 0;
    wait_den("sim1_first_seen");
    check("sim1_first_lat", 32'(last_den_cyc - t), 32'd2);
    check("sim1_first_addr", 32'(last_den_addr), 32'h011);
    check("sim1_first_dwe", 32'(last_den_dwe), 32'd1);
    check("sim1_first_di", 32'(last_den_di), 32'hA5A5);
    d1 = last_den_cyc;
    wait_den("sim1_second_seen");
    check("sim1_second_addr", 32'(last_den_addr), 32'h1B0);
    check("sim1_spacing", 32'(last_den_cyc - d1), 32'd4);
    wait_rsp(1'b1, "sim1_b_done");
    tick(2);
    a_den = 1; b_den = 1;
    tick(1);
    a_den = 0; b_den = 0;
    wait_den("sim2_first_seen");
    check("sim2_first_addr", 32'(last_den_addr), 32'h1B0);
    wait_den("sim2_second_seen");
    check("sim2_second_addr", 32'(last_den_addr), 32'h011);
    wait_rsp(1'b0, "sim2_a_done");
    tick(2);

    // busy rejection
    resp_delay = 2; n0 = den_cnt; a0 = a_cnt;
    req_a(1'b0, 9'h033, 16'h0000);
    tick(1);
    req_a(1'b0, 9'h144, 16'h0000);
    tick(20);
    check("busy_den_count", 32'(den_cnt - n0), 32'd1);
    check("busy_drdy_count", 32'(a_cnt - a0), 32'd1);
    check("busy_addr", 32'(last_den_addr), 32'h033);

    // drdy in the final wait cycle, then a stray drdy while idle
    resp_delay = T + 1; resp_data = 16'h5AC3;
    req_a(1'b0, 9'h0E1, 16'h0000);
    wait_den("coll_den_seen");
    wait_rsp(1'b0, "coll_drdy_seen");
    check("coll_lat", 32'(last_a_cyc - last_den_cyc), 32'(T + 2));
    check("coll_timeout", 32'(last_a_to), 32'd0);
    check("coll_do", 32'(last_a_do), 32'h5AC3);
    check("coll_count", 32'(timeout_count), 32'd0);
    tick(3);
    a0 = a_cnt; b0 = b_cnt;
    stray_req = 1'b1;
    tick(6);
    check("stray_a", 32'(a_cnt - a0), 32'd0);
    check("stray_b", 32'(b_cnt - b0), 32'd0);

    // timeout and counter saturation
    resp_delay = 0;
    req_b(1'b0, 9'h0AA, 16'h0000);
    wait_den("to_den_seen");
    wait_rsp(1'b1, "to_drdy_seen");
    check("to_lat", 32'(last_b_cyc - last_den_cyc), 32'(T + 2));
    check("to_flag", 32'(last_b_to), 32'd1);
    check("to_do", 32'(last_b_do), 32'hFFFF);
    check("to_count", 32'(timeout_count), 32'd1);
    check("to_sticky", 32'(timeout_sticky), 32'd1);
    for (int i = 0; i < 299; i++) begin
      req_b(1'b0, 9'(i), 16'h0000);
      wait_rsp(1'b1, "sat_drdy_seen");
    end
    check("sat_count", 32'(timeout_count), 32'd255);

    // asynchronous reset while waiting
    req_a(1'b0, 9'h07E, 16'h0000);
    wait_den("ar_den_seen");
    tick(3);
    check("ar_busy_before", 32'(a_busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("ar_drp", 32'({drp_den, drp_dwe, drp_daddr, drp_di}), 32'd0);
    check("ar_a", 32'({a_do, a_drdy, a_timeout, a_busy}), 32'd0);
    check("ar_b", 32'({b_do, b_drdy, b_timeout, b_busy}), 32'd0);
    check("ar_err", 32'({timeout_count, timeout_sticky}), 32'd0);
    tick(2);
    @(negedge drp_clk);
    #2 reset_n = 1'b1;
    tick(1);
    a0 = a_cnt;
    tick(5);
    check("ar_no_residual", 32'(a_cnt - a0), 32'd0);
    resp_delay = 3; resp_data = 16'hBEEF;
    req_a(1'b0, 9'h0C3, 16'h0000);
    wait_rsp(1'b0, "ar_new_drdy_seen");
    check("ar_new_count", 32'(a_cnt - a0), 32'd1);
    check("ar_new_do", 32'(last_a_do), 32'hBEEF);
    check("ar_new_timeout", 32'(last_a_to), 32'd0);

    // both requesters hammering: grants must alternate A, B, A, B
    resp_delay = 1;
    den_log.delete();
    a_den = 1; a_dwe = 0; a_daddr = 9'h0A0;
    b_den = 1; b_dwe = 0; b_daddr = 9'h0B0;
    tick(40);
    a_den = 0; b_den = 0;
    check("alt_grants", 32'(den_log.size() >= 4), 32'd1);
    if (den_log.size() >= 4) begin
      check("alt_0", 32'(den_log[0]), 32'h0A0);
      check("alt_1", 32'(den_log[1]), 32'h0B0);
      check("alt_2", 32'(den_log[2]), 32'h0A0);
      check("alt_3", 32'(den_log[3]), 32'h0B0);
    end
    tick(20);

    // randomized traffic
    resp_rand = 1;
    for (int i = 0; i < 800; i++) begin
      a_den = ($urandom_range(0, 3) == 0);
      a_dwe = 1'($urandom_range(0, 1));
      a_daddr = 9'($urandom_range(0, 511));
      a_di = 16'($urandom);
      b_den = ($urandom_range(0, 3) == 0);
      b_dwe = 1'($urandom_range(0, 1));
      b_daddr = 9'($urandom_range(0, 511));
      b_di = 16'($urandom);
      resp_delay = $urandom_range(1, 11);
      if ($urandom_range(0, 15) == 0) stray_req = 1'b1;
      tick(1);
    end
    a_den = 0; b_den = 0; resp_delay = 1;
    tick(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // watchdog
  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
